// File: rtl/cpu_pipe_pkg.sv
// Shared MEM->WB pipeline types.
// Contents:
//   MEMWB_* : default field widths.
//   EMPTY / HEAD / FULL : skid-buffer state encodings.
//   skid_state_e : state enum built on those encodings.
//   mem_wb_t : MEM->WB bus payload at the default widths.
package cpu_pipe_pkg;

  localparam int unsigned MEMWB_XLEN   = 32;
  localparam int unsigned MEMWB_REG_AW = 5;
  localparam int unsigned MEMWB_PC_W   = 32;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HEAD  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = EMPTY,
    S_HEAD  = HEAD,
    S_FULL  = FULL
  } skid_state_e;

  typedef struct packed {
    logic                    wb_en;
    logic                    mem_r_en;
    logic [MEMWB_XLEN-1:0]   alu_result;
    logic [MEMWB_XLEN-1:0]   mem_rdata;
    logic [MEMWB_REG_AW-1:0] dest;
    logic [MEMWB_PC_W-1:0]   pc;
  } mem_wb_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer with a registered upstream ready.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   flush                : drop all held entries (wins over the handshake)
//   in_valid/in_ready    : upstream handshake, in_ready is registered
//   in_data              : upstream payload
//   out_valid/out_ready  : downstream handshake, out_valid is registered
//   out_data             : head payload
module pipe_skid_buf
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         acc, pop;

  assign acc = in_valid & in_ready_q;
  assign pop = (state_q != S_EMPTY) & out_ready;

  // Next-state and payload steering; flush clears valid only, data is kept.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (acc) begin
          state_d = S_HEAD;
          head_d  = in_data;
        end
      end
      S_HEAD: begin
        if (acc && !pop) begin
          state_d = S_FULL;
          skid_d  = in_data;
        end else if (pop && !acc) begin
          state_d = S_EMPTY;
        end else if (acc && pop) begin
          head_d = in_data;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d = S_HEAD;
          head_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d = S_EMPTY;
    end
    // Ready looks only at our own next state, never at out_ready directly.
    in_ready_d = (state_d != S_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = head_q;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: skid-buffered handshake, writeback data select
// and forwarding qualifier for the hazard unit.
// Optional feature macro: MEMWB_PERF_CNT_EN adds stall_cnt / bubble_cnt.
// Ports:
//   clk, rst_n, flush          : clock, sync active-low reset, pipeline flush
//   in_valid/in_ready + in_*   : MEM stage entry
//   out_valid/out_ready + out_*: head entry toward WB
//   wb_data                    : load ? mem_rdata : alu_result of the head
//   fwd_valid                  : head will write a non-zero register
//   stall_cnt, bubble_cnt      : saturating perf counters (macro only)
module mem_wb_pipe_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = MEMWB_XLEN,
  parameter int unsigned REG_AW = MEMWB_REG_AW,
  parameter int unsigned PC_W   = MEMWB_PC_W
`ifdef MEMWB_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_mem_rdata,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic [XLEN-1:0]   out_alu_result,
  output logic [XLEN-1:0]   out_mem_rdata,
  output logic [REG_AW-1:0] out_dest,
  output logic [PC_W-1:0]   out_pc,
  output logic [XLEN-1:0]   wb_data,
  output logic              fwd_valid
`ifdef MEMWB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Same layout as mem_wb_t, sized by this instance's parameters.
  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   mem_rdata;
    logic [REG_AW-1:0] dest;
    logic [PC_W-1:0]   pc;
  } entry_t;

  localparam int unsigned EntryW = $bits(entry_t);

  entry_t in_entry, head;

  assign in_entry = '{
    wb_en:      in_wb_en,
    mem_r_en:   in_mem_r_en,
    alu_result: in_alu_result,
    mem_rdata:  in_mem_rdata,
    dest:       in_dest,
    pc:         in_pc
  };

  pipe_skid_buf #(
    .W(EntryW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign out_mem_r_en   = head.mem_r_en;
  assign out_alu_result = head.alu_result;
  assign out_mem_rdata  = head.mem_rdata;
  assign out_dest       = head.dest;
  assign out_pc         = head.pc;

  // x0 is hardwired zero: never report a write to it.
  assign out_wb_en = head.wb_en & (head.dest != '0);
  assign wb_data   = head.mem_r_en ? head.mem_rdata : head.alu_result;
  assign fwd_valid = out_valid & out_wb_en;

`ifdef MEMWB_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  // Saturating counters; flush deliberately does not clear them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (!out_valid && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg with hand-computed expectations.
module tb_mem_wb_pipe_reg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned PC_W   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_wb_en;
  logic              in_mem_r_en;
  logic [XLEN-1:0]   in_alu_result;
  logic [XLEN-1:0]   in_mem_rdata;
  logic [REG_AW-1:0] in_dest;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic              out_wb_en;
  logic              out_mem_r_en;
  logic [XLEN-1:0]   out_alu_result;
  logic [XLEN-1:0]   out_mem_rdata;
  logic [REG_AW-1:0] out_dest;
  logic [PC_W-1:0]   out_pc;
  logic [XLEN-1:0]   wb_data;
  logic              fwd_valid;
`ifdef MEMWB_PERF_CNT_EN
  logic [3:0]        stall_cnt;
  logic [3:0]        bubble_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_reg #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW),
    .PC_W   (PC_W)
`ifdef MEMWB_PERF_CNT_EN
    ,
    .CNT_W  (4)
`endif
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_wb_en       (in_wb_en),
    .in_mem_r_en    (in_mem_r_en),
    .in_alu_result  (in_alu_result),
    .in_mem_rdata   (in_mem_rdata),
    .in_dest        (in_dest),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_wb_en      (out_wb_en),
    .out_mem_r_en   (out_mem_r_en),
    .out_alu_result (out_alu_result),
    .out_mem_rdata  (out_mem_rdata),
    .out_dest       (out_dest),
    .out_pc         (out_pc),
    .wb_data        (wb_data),
    .fwd_valid      (fwd_valid)
`ifdef MEMWB_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .bubble_cnt     (bubble_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are observed 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic mr,
                       input logic [31:0] alu, input logic [31:0] rd,
                       input logic [4:0] dst, input logic [31:0] pc);
    in_valid      = v;
    in_wb_en      = wb;
    in_mem_r_en   = mr;
    in_alu_result = alu;
    in_mem_rdata  = rd;
    in_dest       = dst;
    in_pc         = pc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h5A5A, 32'hA5A5, 5'd3, 32'h40);

    // Reset held 3 cycles with in_valid asserted.
    repeat (3) tick();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_alu", 64'(out_alu_result), 64'd0);
    check_eq("rst_dest", 64'(out_dest), 64'd0);
    check_eq("rst_pc", 64'(out_pc), 64'd0);
    check_eq("rst_wb_data", 64'(wb_data), 64'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    check_eq("rel_in_ready", 64'(in_ready), 64'd1);
    check_eq("rel_out_valid", 64'(out_valid), 64'd0);

    // Stream of 8 back-to-back loads.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'hA0 + 32'(i), 32'h100 + 32'(i), 5'(i), 32'h1000 + 32'(4 * i));
      tick();
      check_eq($sformatf("strm_valid%0d", i), 64'(out_valid), 64'd1);
      check_eq($sformatf("strm_dest%0d", i), 64'(out_dest), 64'(i));
      check_eq($sformatf("strm_wbdata%0d", i), 64'(wb_data), 64'h100 + 64'(i));
      check_eq($sformatf("strm_pc%0d", i), 64'(out_pc), 64'h1000 + 64'(4 * i));
      check_eq($sformatf("strm_rdy%0d", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check_eq("strm_drain", 64'(out_valid), 64'd0);

    // Backpressure: A then B with WB stalled.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 5'd5, 32'h200);
    tick();
    check_eq("bp_a_alu", 64'(out_alu_result), 64'h11);
    check_eq("bp_a_rdy", 64'(in_ready), 64'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 5'd6, 32'h204);
    tick();
    check_eq("bp_full_rdy", 64'(in_ready), 64'd0);
    check_eq("bp_full_alu", 64'(out_alu_result), 64'h11);
    check_eq("bp_full_wbd", 64'(wb_data), 64'h11);
    drive(1'b1, 1'b1, 1'b0, 32'h33, 32'h0, 5'd7, 32'h208);
    tick();
    check_eq("bp_hold_alu", 64'(out_alu_result), 64'h11);
    check_eq("bp_hold_dest", 64'(out_dest), 64'd5);
    check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("bp_b_alu", 64'(out_alu_result), 64'h22);
    check_eq("bp_b_valid", 64'(out_valid), 64'd1);
    check_eq("bp_b_rdy", 64'(in_ready), 64'd1);
    tick();
    check_eq("bp_empty", 64'(out_valid), 64'd0);

    // Flush in FULL with in_valid asserted.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd9, 32'h300);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd10, 32'h304);
    tick();
    check_eq("fl_full_rdy", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h66, 32'h0, 5'd11, 32'h308);
    tick();
    check_eq("fl_valid", 64'(out_valid), 64'd0);
    check_eq("fl_rdy", 64'(in_ready), 64'd1);
    check_eq("fl_keep_alu", 64'(out_alu_result), 64'h44);
    check_eq("fl_fwd", 64'(fwd_valid), 64'd0);
    // Flush in HEAD while an accept happens: the accept is dropped.
    flush = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h77, 32'h0, 5'd12, 32'h30C);
    tick();
    check_eq("fl2_head", 64'(out_alu_result), 64'h77);
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h88, 32'h0, 5'd13, 32'h310);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("fl2_valid", 64'(out_valid), 64'd0);
    tick();
    check_eq("fl2_dropped", 64'(out_valid), 64'd0);

    // Zero destination suppression.
    drive(1'b1, 1'b1, 1'b0, 32'hDEAD, 32'h0, 5'd0, 32'h400);
    tick();
    check_eq("z_valid", 64'(out_valid), 64'd1);
    check_eq("z_wb_en", 64'(out_wb_en), 64'd0);
    check_eq("z_fwd", 64'(fwd_valid), 64'd0);
    check_eq("z_wbdata", 64'(wb_data), 64'hDEAD);
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'hBEEF, 32'h0, 5'd7, 32'h404);
    tick();
    check_eq("nz_wb_en", 64'(out_wb_en), 64'd1);
    check_eq("nz_fwd", 64'(fwd_valid), 64'd1);
    check_eq("nz_dest", 64'(out_dest), 64'd7);
    in_valid = 1'b0;
    tick();

    // Reset while FULL discards everything.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h91, 32'h0, 5'd1, 32'h500);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h92, 32'h0, 5'd2, 32'h504);
    tick();
    rst_n = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("rmid_valid", 64'(out_valid), 64'd0);
    check_eq("rmid_rdy", 64'(in_ready), 64'd0);
    check_eq("rmid_alu", 64'(out_alu_result), 64'd0);
    in_valid  = 1'b0;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    check_eq("rmid_after", 64'(out_valid), 64'd0);

`ifdef MEMWB_PERF_CNT_EN
    // Perf counters with CNT_W=4.
    out_ready = 1'b0;
    do_reset();
    check_eq("pc_bubble_rel", 64'(bubble_cnt), 64'd1);
    check_eq("pc_stall_rel", 64'(stall_cnt), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 32'hC0, 32'h0, 5'd4, 32'h600);
    tick();
    in_valid = 1'b0;
    check_eq("pc_bubble_acc", 64'(bubble_cnt), 64'd2);
    repeat (5) tick();
    check_eq("pc_stall5", 64'(stall_cnt), 64'd5);
    repeat (15) tick();
    check_eq("pc_stall_sat", 64'(stall_cnt), 64'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("pc_noclr", 64'(stall_cnt), 64'd15);
`else
    do_reset();
    check_eq("final_valid", 64'(out_valid), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
